multicycle_main_ctl: RTL and testbench

Main control FSM for the multicycle RV32I core. It sequences the single shared ALU, the register file, the IR/PC registers and the unified memory port across the FETCH/DECODE/EXECUTE/WRITEBACK steps. It drives o_alu_op into Control_ALU, which turns it into the 3-bit ALU control together with funct3/funct7. It supports lw, sw, R-type ALU, I-type ALU, jal and beq, with a memory-ready wait handshake and an instruction-retire counter.

---
 rtl/multicycle_main_ctl.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_main_ctl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_ctl.sv
// rtl/multicycle_main_ctl.sv - main control FSM for the multicycle RV32I core
//
// Sequences the shared ALU, register file, IR/PC and the unified memory port
// through FETCH / DECODE / EXECUTE / WRITEBACK for lw, sw, R-type, I-type,
// jal and beq, and counts retired instructions.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_op           opcode from the instruction register
//   i_zero         ALU zero flag (beq decision)
//   i_mem_ready    memory completes the current access this cycle
//   o_pc_write     PC register enable
//   o_adr_src      memory address select: 0 PC, 1 Result
//   o_mem_write    memory write strobe
//   o_ir_write     IR / OldPC enable
//   o_result_src   00 ALUOut, 01 ReadData, 10 ALUResult
//   o_alu_src_a    00 PC, 01 OldPC, 10 RD1
//   o_alu_src_b    00 RD2, 01 ImmExt, 10 constant 4
//   o_alu_op       00 add, 01 sub, 10 decode funct
//   o_reg_write    register-file write enable
//   o_illegal      illegal opcode indication
//   o_state        current state encoding (debug)
//   o_retired      completed-instruction counter

module multicycle_main_ctl #(
  parameter int CNT_W           = 32,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_op,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_adr_src,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic [1:0]       o_result_src,
  output logic [1:0]       o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic             o_reg_write,
  output logic             o_illegal,
  output logic [3:0]       o_state,
  output logic [CNT_W-1:0] o_retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t state;
  logic   legal_op;

  assign legal_op = (i_op == OP_LW) || (i_op == OP_SW) || (i_op == OP_R) ||
                    (i_op == OP_I)  || (i_op == OP_JAL) || (i_op == OP_BEQ);

  assign o_state = state;

  // State transitions and the retire counter share one register block so
  // that "leaving a retiring state" is evaluated on the same edge as the move.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_FETCH;
      o_retired <= '0;
    end else begin
      case (state)
        S_FETCH:    if (i_mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (i_op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXECUTER;
            OP_I:         state <= S_EXECUTEI;
            OP_JAL:       state <= S_JAL;
            OP_BEQ:       state <= S_BEQ;
            default:      state <= (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
          endcase
        end
        S_MEMADR:   state <= (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (i_mem_ready) state <= S_MEMWB;
        S_MEMWB: begin
          state     <= S_FETCH;
          o_retired <= o_retired + CNT_W'(1);
        end
        S_MEMWRITE: begin
          if (i_mem_ready) begin
            state     <= S_FETCH;
            o_retired <= o_retired + CNT_W'(1);
          end
        end
        S_EXECUTER: state <= S_ALUWB;
        S_EXECUTEI: state <= S_ALUWB;
        S_ALUWB: begin
          state     <= S_FETCH;
          o_retired <= o_retired + CNT_W'(1);
        end
        S_JAL:      state <= S_ALUWB;
        S_BEQ: begin
          state     <= S_FETCH;
          o_retired <= o_retired + CNT_W'(1);
        end
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Outputs follow the state directly; FETCH and BEQ gate their enables with
  // the live handshake/flag so the PC is written exactly once per access.
  always_comb begin
    o_pc_write   = 1'b0;
    o_adr_src    = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_result_src = 2'b00;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_alu_op     = 2'b00;
    o_reg_write  = 1'b0;
    o_illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        o_ir_write   = i_mem_ready;
        o_pc_write   = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
        o_illegal   = (TRAP_ON_ILLEGAL == 0) && !legal_op;
      end
      S_MEMADR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        o_adr_src = 1'b1;
      end
      S_MEMWB: begin
        o_result_src = 2'b01;
        o_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o_adr_src   = 1'b1;
        o_mem_write = 1'b1;
      end
      S_EXECUTER: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        o_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        o_reg_write = 1'b1;
      end
      S_JAL: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b10;
        o_pc_write  = 1'b1;
      end
      S_BEQ: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = 2'b01;
        o_pc_write  = i_zero;
      end
      S_TRAP: begin
        o_illegal = 1'b1;
      end
      default: ;
    endcase
    // No architectural write may slip out while reset is held.
    if (i_rst) begin
      o_pc_write  = 1'b0;
      o_mem_write = 1'b0;
      o_ir_write  = 1'b0;
      o_reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_ctl.sv
// tb/tb_multicycle_main_ctl.sv - randomized self-checking bench for multicycle_main_ctl

module tb_multicycle_main_ctl;

  logic clk;
  logic rst;
  logic [6:0] op;
  logic zero;
  logic rdy;

  logic pcw0, adr0, mw0, irw0, rw0, ill0;
  logic [1:0] rs0, a0, b0, aop0;
  logic [3:0] st0;
  logic [31:0] ret0;
  logic pcw1, adr1, mw1, irw1, rw1, ill1;
  logic [1:0] rs1, a1, b1, aop1;
  logic [3:0] st1;
  logic [31:0] ret1;

  multicycle_main_ctl #(.CNT_W(32), .TRAP_ON_ILLEGAL(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_zero(zero), .i_mem_ready(rdy),
    .o_pc_write(pcw0), .o_adr_src(adr0), .o_mem_write(mw0), .o_ir_write(irw0),
    .o_result_src(rs0), .o_alu_src_a(a0), .o_alu_src_b(b0), .o_alu_op(aop0),
    .o_reg_write(rw0), .o_illegal(ill0), .o_state(st0), .o_retired(ret0)
  );

  multicycle_main_ctl #(.CNT_W(32), .TRAP_ON_ILLEGAL(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_zero(zero), .i_mem_ready(rdy),
    .o_pc_write(pcw1), .o_adr_src(adr1), .o_mem_write(mw1), .o_ir_write(irw1),
    .o_result_src(rs1), .o_alu_src_a(a1), .o_alu_src_b(b1), .o_alu_op(aop1),
    .o_reg_write(rw1), .o_illegal(ill1), .o_state(st1), .o_retired(ret1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JAL = 7'b1101111, BEQ = 7'b1100011;

  // Per-cycle expectation: {state, pcw, adr, mw, irw, rs, a, b, aop, rw, ill}
  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic        zero;
    logic [17:0] v;
    logic [31:0] ret;
  } cyc_t;

  cyc_t q[$];
  logic [31:0] mcnt;
  int ncmp;
  int nfail;

  // Expected control word for one cycle, straight from the state table.
  task automatic push(input int st, input logic [6:0] o, input logic r,
                      input logic z, input bit retires);
    cyc_t c;
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, a, b, aop;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 0; a = 0; b = 0; aop = 0;
    case (st)
      0:  begin b = 2; rs = 2; irw = r; pcw = r; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2; aop = 2; end
      7:  rw = 1;
      8:  begin a = 2; b = 1; aop = 2; end
      9:  begin a = 1; b = 2; pcw = 1; end
      10: begin a = 2; aop = 1; pcw = z; end
      11: ill = 1;
      default: ;
    endcase
    c.op = o; c.rdy = r; c.zero = z;
    c.v = {4'(st), pcw, adr, mw, irw, rs, a, b, aop, rw, ill};
    c.ret = mcnt;
    if (retires) mcnt = mcnt + 1;
    q.push_back(c);
  endtask

  // Expected cycle sequence of a whole instruction.
  task automatic gen_instr(input logic [6:0] o, input logic z, input int fw, input int mwait);
    for (int i = 0; i < fw; i++) push(0, 7'($urandom), 0, z, 0);
    push(0, 7'($urandom), 1, z, 0);
    push(1, o, 1'($urandom), z, 0);
    case (o)
      LW: begin
        push(2, o, 1'($urandom), z, 0);
        for (int i = 0; i < mwait; i++) push(3, o, 0, z, 0);
        push(3, o, 1, z, 0);
        push(4, o, 1'($urandom), z, 1);
      end
      SW: begin
        push(2, o, 1'($urandom), z, 0);
        for (int i = 0; i < mwait; i++) push(5, o, 0, z, 0);
        push(5, o, 1, z, 1);
      end
      RT: begin push(6, o, 1'($urandom), z, 0); push(7, o, 1'($urandom), z, 1); end
      IT: begin push(8, o, 1'($urandom), z, 0); push(7, o, 1'($urandom), z, 1); end
      JAL: begin push(9, o, 1'($urandom), z, 0); push(7, o, 1'($urandom), z, 1); end
      BEQ: push(10, o, 1'($urandom), z, 1);
      default: ;
    endcase
  endtask

  // Drive one cycle of stimulus and sample both DUTs mid-cycle.
  task automatic run_cyc(input cyc_t c, output logic [17:0] o0, output logic [17:0] o1,
                         output logic [31:0] r0, output logic [31:0] r1);
    op = c.op; rdy = c.rdy; zero = c.zero;
    @(negedge clk);
    o0 = {st0, pcw0, adr0, mw0, irw0, rs0, a0, b0, aop0, rw0, ill0};
    o1 = {st1, pcw1, adr1, mw1, irw1, rs1, a1, b1, aop1, rw1, ill1};
    r0 = ret0; r1 = ret1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [17:0] want;
    rst = 1; rdy = 1; op = RT; zero = 1;
    want = {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    @(negedge clk);
    ncmp++;
    if ({st0, pcw0, adr0, mw0, irw0, rs0, a0, b0, aop0, rw0, ill0} !== want) begin
      nfail++;
      $display("FAIL reset_outputs: got %h want %h",
               {st0, pcw0, adr0, mw0, irw0, rs0, a0, b0, aop0, rw0, ill0}, want);
    end
    ncmp++;
    if (ret0 !== 32'd0 || ret1 !== 32'd0) begin
      nfail++; $display("FAIL reset_retired: got %0d/%0d want 0", ret0, ret1);
    end
    @(posedge clk); #1;
    rst = 0; mcnt = 0;
  endtask

  task automatic test_alu_ops;
    cyc_t c; logic [17:0] o0, o1; logic [31:0] r0, r1; int k;
    gen_instr(RT, 0, 0, 0);
    gen_instr(IT, 1, 1, 0);
    gen_instr(JAL, 0, 0, 0);
    k = 0;
    while (q.size() > 0) begin
      c = q.pop_front(); run_cyc(c, o0, o1, r0, r1);
      ncmp++; if (o0 !== c.v) begin nfail++; $display("FAIL alu_ctl cyc%0d: got %h want %h", k, o0, c.v); end
      ncmp++; if (r0 !== c.ret) begin nfail++; $display("FAIL alu_retired cyc%0d: got %0d want %0d", k, r0, c.ret); end
      ncmp++; if (o1 !== c.v || r1 !== c.ret) begin nfail++; $display("FAIL alu_dut1 cyc%0d: got %h/%0d want %h/%0d", k, o1, r1, c.v, c.ret); end
      k++;
    end
  endtask

  task automatic test_memory;
    cyc_t c; logic [17:0] o0, o1; logic [31:0] r0, r1; int k;
    gen_instr(LW, 0, 3, 3);
    gen_instr(SW, 1, 0, 2);
    gen_instr(LW, 1, 0, 0);
    gen_instr(SW, 0, 2, 0);
    k = 0;
    while (q.size() > 0) begin
      c = q.pop_front(); run_cyc(c, o0, o1, r0, r1);
      ncmp++; if (o0 !== c.v) begin nfail++; $display("FAIL mem_ctl cyc%0d: got %h want %h", k, o0, c.v); end
      ncmp++; if (r0 !== c.ret) begin nfail++; $display("FAIL mem_retired cyc%0d: got %0d want %0d", k, r0, c.ret); end
      ncmp++; if (o1 !== c.v || r1 !== c.ret) begin nfail++; $display("FAIL mem_dut1 cyc%0d: got %h/%0d want %h/%0d", k, o1, r1, c.v, c.ret); end
      k++;
    end
  endtask

  task automatic test_branch;
    cyc_t c; logic [17:0] o0, o1; logic [31:0] r0, r1; int k;
    gen_instr(BEQ, 1, 0, 0);
    gen_instr(BEQ, 0, 0, 0);
    k = 0;
    while (q.size() > 0) begin
      c = q.pop_front(); run_cyc(c, o0, o1, r0, r1);
      ncmp++; if (o0 !== c.v) begin nfail++; $display("FAIL beq_ctl cyc%0d: got %h want %h", k, o0, c.v); end
      ncmp++; if (r0 !== c.ret) begin nfail++; $display("FAIL beq_retired cyc%0d: got %0d want %0d", k, r0, c.ret); end
      k++;
    end
  endtask

  task automatic test_random;
    cyc_t c; logic [17:0] o0, o1; logic [31:0] r0, r1; int k;
    logic [6:0] ops [6];
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = JAL; ops[5] = BEQ;
    for (int i = 0; i < 40; i++)
      gen_instr(ops[$urandom_range(5, 0)], 1'($urandom), $urandom_range(3, 0), $urandom_range(3, 0));
    k = 0;
    while (q.size() > 0) begin
      c = q.pop_front(); run_cyc(c, o0, o1, r0, r1);
      ncmp++; if (o0 !== c.v) begin nfail++; $display("FAIL rand_ctl cyc%0d: got %h want %h", k, o0, c.v); end
      ncmp++; if (r0 !== c.ret) begin nfail++; $display("FAIL rand_retired cyc%0d: got %0d want %0d", k, r0, c.ret); end
      ncmp++; if (o1 !== c.v || r1 !== c.ret) begin nfail++; $display("FAIL rand_dut1 cyc%0d: got %h/%0d want %h/%0d", k, o1, r1, c.v, c.ret); end
      k++;
    end
  endtask

  task automatic test_reset_mid;
    cyc_t c; logic [17:0] o0, o1; logic [31:0] r0, r1; int k;
    gen_instr(RT, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      c = q.pop_front(); run_cyc(c, o0, o1, r0, r1);
      ncmp++; if (o0 !== c.v) begin nfail++; $display("FAIL mid_pre cyc%0d: got %h want %h", i, o0, c.v); end
    end
    // now sitting in ALUWB; reset must suppress its register write
    rst = 1; rdy = 1;
    @(negedge clk);
    ncmp++;
    if (st0 !== 4'd0 || rw0 !== 1'b0 || pcw0 !== 1'b0 || irw0 !== 1'b0 || mw0 !== 1'b0) begin
      nfail++; $display("FAIL mid_reset_enables: got st%0d rw%b pcw%b irw%b mw%b want st0 all 0", st0, rw0, pcw0, irw0, mw0);
    end
    ncmp++;
    if (ret0 !== 32'd0) begin nfail++; $display("FAIL mid_reset_retired: got %0d want 0", ret0); end
    @(posedge clk); #1;
    rst = 0; q.delete(); mcnt = 0;
    gen_instr(RT, 0, 0, 0);
    k = 0;
    while (q.size() > 0) begin
      c = q.pop_front(); run_cyc(c, o0, o1, r0, r1);
      ncmp++; if (o0 !== c.v || r0 !== c.ret) begin nfail++; $display("FAIL mid_post cyc%0d: got %h/%0d want %h/%0d", k, o0, r0, c.v, c.ret); end
      k++;
    end
  endtask

  task automatic test_illegal;
    cyc_t c; logic [17:0] o0, o1; logic [31:0] r0, r1; logic [31:0] base; int k;
    base = mcnt;
    push(0, 7'($urandom), 1, 0, 0);
    push(1, 7'h7f, 1, 0, 0);
    for (int i = 0; i < 5; i++) push(11, 7'h7f, 1'($urandom), 1'($urandom), 0);
    k = 0;
    while (q.size() > 0) begin
      c = q.pop_front(); run_cyc(c, o0, o1, r0, r1);
      ncmp++; if (o0 !== c.v || r0 !== c.ret) begin nfail++; $display("FAIL trap_ctl cyc%0d: got %h/%0d want %h/%0d", k, o0, r0, c.v, c.ret); end
      if (k == 1) begin
        ncmp++; if (o1 !== (c.v | 18'h1)) begin nfail++; $display("FAIL pulse_decode: got %h want %h", o1, c.v | 18'h1); end
      end
      if (k == 2) begin
        ncmp++;
        if (o1[17:14] !== 4'd0 || o1[0] !== 1'b0 || r1 !== base) begin
          nfail++; $display("FAIL pulse_after: got st%0d ill%b ret%0d want st0 ill0 ret%0d", o1[17:14], o1[0], r1, base);
        end
      end
      k++;
    end
    rst = 1;
    @(negedge clk);
    ncmp++;
    if (st0 !== 4'd0 || ill0 !== 1'b0 || ret0 !== 32'd0 || ret1 !== 32'd0) begin
      nfail++; $display("FAIL trap_reset: got st%0d ill%b ret%0d/%0d want st0 ill0 ret0", st0, ill0, ret0, ret1);
    end
    @(posedge clk); #1;
    rst = 0; mcnt = 0;
    @(negedge clk);
    ncmp++;
    if (st0 !== 4'd0) begin nfail++; $display("FAIL trap_release: got st%0d want 0", st0); end
  endtask

  initial begin
    ncmp = 0; nfail = 0; mcnt = 0;
    rst = 1; rdy = 0; op = 7'd0; zero = 0;
    test_reset();
    test_alu_ops();
    test_memory();
    test_branch();
    test_random();
    test_reset_mid();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
